vram_sync_copier: RTL and testbench

- On a one-cycle `sync` request, copies the whole producer-side VRAM image into the consumer-side VRAM, one word per cycle.
- Sits beside the double-buffered VRAM in the PPU. After a buffer swap, the consumer copy is brought up to date with the producer copy.
- The producer read port and consumer write port are the flattened signals of the codebase's `vram_if` bundles (P side read, C side write).
- Pulses `done` once the last word is written.

---
 rtl/vram_sync_copier.sv | 57 +++++
 tb/tb_vram_sync_copier.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vram_sync_copier.sv
// vram_sync_copier: on a sync pulse, streams all 2**ADDR_W producer VRAM words into the consumer VRAM.
// Optional: define VRAM_SYNC_RESTART_EN to let sync during COPY/DRAIN restart the copy from address 0.
module vram_sync_copier #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sync,
   output logic              done,
   output logic              src_rden,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0] src_rddata,
   output logic              dst_wren,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [DATA_W-1:0] dst_wrdata
);
   typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;
   state_t r_state, w_next;
   logic [ADDR_W-1:0] r_cnt, r_wa;
   logic r_wv, w_last, w_restart;
   assign w_last = r_cnt == '1;
`ifdef VRAM_SYNC_RESTART_EN
   assign w_restart = sync && (r_state == COPY || r_state == DRAIN);
`else
   assign w_restart = 1'b0;
`endif
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = sync ? COPY : IDLE;
         COPY:    w_next = w_restart ? COPY : (w_last ? DRAIN : COPY);
         DRAIN:   w_next = w_restart ? COPY : DONE;
         default: w_next = IDLE;
      endcase
   end
   // The write stage trails the read stage by the one-cycle read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wa    <= '0;
         r_wv    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == COPY && !w_restart && !w_last) ? r_cnt + 1'b1 : '0;
         r_wa    <= r_cnt;
         r_wv    <= src_rden;
      end
   end
   assign src_rden   = r_state == COPY;
   assign src_addr   = src_rden ? r_cnt : '0;
   assign dst_wren   = r_wv;
   assign dst_addr   = r_wv ? r_wa : '0;
   assign dst_wrdata = r_wv ? src_rddata : '0;
   assign done       = r_state == DONE;
endmodule

// File: tb/tb_vram_sync_copier.sv
// tb_vram_sync_copier: table spot checks plus a cycle-level reference model of the copy
// (reads derived from the start cycle, writes as the reads delayed by one cycle).
module tb_vram_sync_copier;
   localparam int AW = 11, DW = 64, N = 1 << AW, TMAX = 2 * N + 8;
   logic clk = 0, rst_n = 0, sync = 0;
   logic done, src_rden, dst_wren;
   logic [AW-1:0] src_addr, dst_addr;
   logic [DW-1:0] src_rddata = '0, dst_wrdata;
   logic [DW-1:0] src[N], dst[N];
   int checks = 0, failures = 0, wr_cnt = 0;
   logic tr_rden[TMAX], tr_wren[TMAX], tr_done[TMAX];
   int tr_raddr[TMAX], tr_waddr[TMAX];
   logic [DW-1:0] tr_wdata[TMAX];

   typedef struct {int cyc; logic rden; int raddr; logic wren; int waddr; logic done;} vec_t;
   vec_t vecs[8];

   vram_sync_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .done(done),
      .src_rden(src_rden), .src_addr(src_addr), .src_rddata(src_rddata),
      .dst_wren(dst_wren), .dst_addr(dst_addr), .dst_wrdata(dst_wrdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (src_rden) src_rddata <= src[src_addr];
   always @(posedge clk) if (dst_wren) begin dst[dst_addr] <= dst_wrdata; wr_cnt++; end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, " src_rden"}, src_rden, 0);
      chk({tag, " src_addr"}, src_addr, 0);
      chk({tag, " dst_wren"}, dst_wren, 0);
      chk({tag, " dst_addr"}, dst_addr, 0);
      chk({tag, " dst_wrdata"}, dst_wrdata, 0);
      chk({tag, " done"}, done, 0);
   endtask

   // extra >= 0: sync is pulsed again in cycle 'extra' of the copy.
   task automatic run_copy(input int extra, input string tag);
      int s, ncyc, bad, first_bad, dones, done_at, k, pr_addr, e_raddr, e_waddr, dmis;
      logic restart, pr_rden, e_rden, e_wren, e_done;
      logic [DW-1:0] e_wdata;
      restart = 1'b0;
`ifdef VRAM_SYNC_RESTART_EN
      restart = extra >= 0 && extra <= N;
`endif
      s = restart ? extra + 1 : 0;
      ncyc = s + N + 4;
      bad = 0; first_bad = -1; dones = 0; done_at = -1; pr_rden = 0; pr_addr = 0;
      @(negedge clk) sync = 1;
      @(posedge clk);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         sync = (c == extra);
         k = c - s;
         e_rden  = (c < s && c < N) || (k >= 0 && k < N);
         e_raddr = !e_rden ? 0 : (c < s ? c : k);
         e_wren  = pr_rden;
         e_waddr = pr_rden ? pr_addr : 0;
         e_wdata = pr_rden ? src[pr_addr] : '0;
         e_done  = c == s + N + 1;
         tr_rden[c] = src_rden; tr_raddr[c] = int'(src_addr); tr_wren[c] = dst_wren;
         tr_waddr[c] = int'(dst_addr); tr_wdata[c] = dst_wrdata; tr_done[c] = done;
         if (src_rden !== e_rden || int'(src_addr) != e_raddr || dst_wren !== e_wren ||
             int'(dst_addr) != e_waddr || dst_wrdata !== e_wdata || done !== e_done) begin
            bad++;
            if (first_bad < 0) first_bad = c;
         end
         if (done === 1'b1) begin dones++; done_at = c; end
         pr_rden = e_rden; pr_addr = e_raddr;
      end
      sync = 0;
      if (bad != 0) $display("note: %s first deviating cycle %0d", tag, first_bad);
      chk({tag, " deviating_cycles"}, bad, 0);
      chk({tag, " done_pulses"}, dones, 1);
      chk({tag, " done_cycle"}, done_at, s + N + 1);
      dmis = 0;
      for (int i = 0; i < N; i++) if (dst[i] !== src[i]) dmis++;
      chk({tag, " dst_mismatched_words"}, dmis, 0);
   endtask

   initial begin
      int w0, gap;
      vecs[0] = '{0,    1, 0,    0, 0,    0};
      vecs[1] = '{1,    1, 1,    1, 0,    0};
      vecs[2] = '{2,    1, 2,    1, 1,    0};
      vecs[3] = '{1000, 1, 1000, 1, 999,  0};
      vecs[4] = '{2047, 1, 2047, 1, 2046, 0};
      vecs[5] = '{2048, 0, 0,    1, 2047, 0};
      vecs[6] = '{2049, 0, 0,    0, 0,    1};
      vecs[7] = '{2050, 0, 0,    0, 0,    0};
      for (int i = 0; i < N; i++) begin src[i] = DW'(i * 3 + 'h1234); dst[i] = 64'hDEAD_BEEF_0000_0000 | DW'(i); end

      #1 chk_outputs_zero("reset");
      @(negedge clk) rst_n = 1;
      w0 = wr_cnt;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (src_rden !== 1'b0 || done !== 1'b0) w0 = -1;
      end
      chk("idle_no_activity", w0 == wr_cnt, 1);
      chk("idle_dst_word5", dst[5], 64'hDEAD_BEEF_0000_0005);

      run_copy(-1, "single");
      for (int v = 0; v < 8; v++) begin
         chk($sformatf("vec%0d src_rden", v), tr_rden[vecs[v].cyc], vecs[v].rden);
         chk($sformatf("vec%0d src_addr", v), tr_raddr[vecs[v].cyc], vecs[v].raddr);
         chk($sformatf("vec%0d dst_wren", v), tr_wren[vecs[v].cyc], vecs[v].wren);
         chk($sformatf("vec%0d dst_addr", v), tr_waddr[vecs[v].cyc], vecs[v].waddr);
         chk($sformatf("vec%0d dst_wrdata", v), tr_wdata[vecs[v].cyc],
             vecs[v].wren ? DW'(vecs[v].waddr * 3 + 'h1234) : '0);
         chk($sformatf("vec%0d done", v), tr_done[vecs[v].cyc], vecs[v].done);
      end

      for (int i = 0; i < N; i++) src[i] = {$urandom, $urandom};
      run_copy(1000, "mid_sync");

      for (int r = 0; r < 2; r++) begin
         gap = $urandom_range(1, 20);
         repeat (gap) @(negedge clk);
         for (int i = 0; i < N; i++) src[i] = {$urandom, $urandom};
         run_copy(-1, $sformatf("random%0d", r));
      end

      for (int i = 0; i < N; i++) src[i] = {$urandom, $urandom};
      @(negedge clk) sync = 1;
      @(posedge clk);
      for (int c = 0; c <= 500; c++) begin @(negedge clk); sync = 0; end
      chk("abort_pre_rden", src_rden, 1);
      rst_n = 0;
      #1 chk_outputs_zero("abort");
      w0 = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done === 1'b1 || src_rden === 1'b1) w0++;
      end
      chk("abort_no_done_or_resume", w0, 0);
      for (int i = 0; i < N; i++) src[i] = {$urandom, $urandom};
      run_copy(-1, "after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
